// File: rtl/ex_result_wb.sv
// ---------------------------------------------------------------------------
// ex_result_wb
// Consumer end of the ALU result interface. Buffers (rd, result) pairs from
// the ALU in a small in-order FIFO, drains them to the register-file write
// port over valid/ready, and offers a youngest-first bypass lookup to issue.
//
// Ports
//   clk_i, rstn_i        clock (rising edge), asynchronous active-low reset
//   alu_vld_i/rd_i/      incoming registered ALU result and destination tag
//   alu_result_i
//   flush_i              discard all buffered results and the incoming one
//   stall_o              issue must not start an ALU op (one slot headroom)
//   wb_vld_o/rdy_i/      register-file write handshake, FIFO head entry
//   wb_rd_o/wb_data_o
//   byp_rs_i             bypass lookup register
//   byp_hit_o/data_o     youngest pending value for byp_rs_i
//   ovf_o                sticky: a push was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module ex_result_wb #(
   parameter int XLEN   = 64,
   parameter int DEPTH  = 4,
   parameter int REG_AW = 5
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic              alu_vld_i,
   input  logic [REG_AW-1:0] alu_rd_i,
   input  logic [XLEN-1:0]   alu_result_i,
   input  logic              flush_i,
   output logic              stall_o,
   output logic              wb_vld_o,
   input  logic              wb_rdy_i,
   output logic [REG_AW-1:0] wb_rd_o,
   output logic [XLEN-1:0]   wb_data_o,
   input  logic [REG_AW-1:0] byp_rs_i,
   output logic              byp_hit_o,
   output logic [XLEN-1:0]   byp_data_o,
   output logic              ovf_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;

   logic [REG_AW-1:0] rd_q   [DEPTH];
   logic [XLEN-1:0]   data_q [DEPTH];

   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;

   logic empty, full, pop, push_req, push_ok;

   assign empty    = (count_q == '0);
   assign full     = (count_q == CW'(DEPTH));
   assign pop      = ~empty & wb_rdy_i;
   assign push_req = alu_vld_i & (alu_rd_i != '0) & ~flush_i;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign push_ok  = push_req & (~full | pop);

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      if (flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (pop)     head_d = head_q + PW'(1);
         if (push_ok) tail_d = tail_q + PW'(1);
         case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
         if (push_req & full & ~pop) ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   // Payload storage needs no reset: slots outside [head, head+count) are
   // never observed on any output.
   always_ff @(posedge clk_i) begin
      if (push_ok) begin
         rd_q[tail_q]   <= alu_rd_i;
         data_q[tail_q] <= alu_result_i;
      end
   end

   assign wb_vld_o  = ~empty;
   assign wb_rd_o   = empty ? '0 : rd_q[head_q];
   assign wb_data_o = empty ? '0 : data_q[head_q];
   assign stall_o   = (count_q >= CW'(DEPTH - 1));
   assign ovf_o     = ovf_q;

   // Slot gi holds the gi-th oldest pending entry.
   logic [PW-1:0]    slot_idx [DEPTH];
   logic [DEPTH-1:0] slot_hit;

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      assign slot_idx[gi] = head_q + PW'(gi);
      assign slot_hit[gi] = (CW'(gi) < count_q) && (rd_q[slot_idx[gi]] == byp_rs_i);
   end

   // Later (younger) matches overwrite older ones; the incoming push wins last.
   always_comb begin
      byp_hit_o  = 1'b0;
      byp_data_o = '0;
      if (byp_rs_i != '0) begin
         for (int k = 0; k < DEPTH; k++) begin
            if (slot_hit[k]) begin
               byp_hit_o  = 1'b1;
               byp_data_o = data_q[slot_idx[k]];
            end
         end
         if (alu_vld_i && (alu_rd_i == byp_rs_i) && !flush_i) begin
            byp_hit_o  = 1'b1;
            byp_data_o = alu_result_i;
         end
      end
   end

endmodule

// File: tb/tb_ex_result_wb.sv
// ---------------------------------------------------------------------------
// tb_ex_result_wb
// Directed stimulus for ex_result_wb. A queue-based model of the result
// buffer is compared against the DUT on every falling edge; directed literal
// expectations pin the model's behaviour at the interesting points.
// ---------------------------------------------------------------------------
module tb_ex_result_wb;

   localparam int XLEN   = 64;
   localparam int DEPTH  = 4;
   localparam int REG_AW = 5;

   logic              clk;
   logic              rstn;
   logic              alu_vld;
   logic [REG_AW-1:0] alu_rd;
   logic [XLEN-1:0]   alu_res;
   logic              flush;
   logic              stall;
   logic              wb_vld;
   logic              wb_rdy;
   logic [REG_AW-1:0] wb_rd;
   logic [XLEN-1:0]   wb_data;
   logic [REG_AW-1:0] byp_rs;
   logic              byp_hit;
   logic [XLEN-1:0]   byp_data;
   logic              ovf;

   int checks   = 0;
   int failures = 0;

   ex_result_wb #(.XLEN(XLEN), .DEPTH(DEPTH), .REG_AW(REG_AW)) dut (
      .clk_i       (clk),
      .rstn_i      (rstn),
      .alu_vld_i   (alu_vld),
      .alu_rd_i    (alu_rd),
      .alu_result_i(alu_res),
      .flush_i     (flush),
      .stall_o     (stall),
      .wb_vld_o    (wb_vld),
      .wb_rdy_i    (wb_rdy),
      .wb_rd_o     (wb_rd),
      .wb_data_o   (wb_data),
      .byp_rs_i    (byp_rs),
      .byp_hit_o   (byp_hit),
      .byp_data_o  (byp_data),
      .ovf_o       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   data;
   } ent_t;

   ent_t mq[$];
   logic m_ovf = 1'b0;

   always @(negedge clk) begin
      logic              e_hit;
      logic [XLEN-1:0]   e_bd;
      logic              m_pop, m_push;
      ent_t              e;
      if (!rstn) begin
         mq.delete();
         m_ovf = 1'b0;
      end else begin
         e_hit = 1'b0;
         e_bd  = '0;
         if (byp_rs != '0) begin
            if (alu_vld && alu_rd == byp_rs && !flush) begin
               e_hit = 1'b1;
               e_bd  = alu_res;
            end else begin
               for (int i = mq.size() - 1; i >= 0; i--) begin
                  if (mq[i].rd == byp_rs) begin
                     e_hit = 1'b1;
                     e_bd  = mq[i].data;
                     break;
                  end
               end
            end
         end
         chk("cmp_stall",   64'(stall),    64'(mq.size() >= DEPTH - 1));
         chk("cmp_wb_vld",  64'(wb_vld),   64'(mq.size() != 0));
         chk("cmp_wb_rd",   64'(wb_rd),    (mq.size() != 0) ? 64'(mq[0].rd) : 64'd0);
         chk("cmp_wb_data", wb_data,       (mq.size() != 0) ? mq[0].data : 64'd0);
         chk("cmp_byp_hit", 64'(byp_hit),  64'(e_hit));
         chk("cmp_byp_data", byp_data,     e_bd);
         chk("cmp_ovf",     64'(ovf),      64'(m_ovf));

         // state the DUT must reach after the coming rising edge
         m_pop  = (mq.size() != 0) && wb_rdy;
         m_push = alu_vld && (alu_rd != '0) && !flush;
         if (m_pop) $display("WB  rd=%0d data=0x%0h", mq[0].rd, mq[0].data);
         if (flush) begin
            mq.delete();
         end else begin
            logic was_full;
            was_full = (mq.size() == DEPTH);
            if (m_pop) void'(mq.pop_front());
            if (m_push) begin
               if (was_full && !m_pop) begin
                  m_ovf = 1'b1;
               end else begin
                  e.rd   = alu_rd;
                  e.data = alu_res;
                  mq.push_back(e);
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int rd, input logic [63:0] d);
      alu_vld = 1'b1;
      alu_rd  = REG_AW'(rd);
      alu_res = d;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
   endtask

   initial begin
      rstn = 1'b0; alu_vld = 1'b0; alu_rd = '0; alu_res = '0;
      flush = 1'b0; wb_rdy = 1'b0; byp_rs = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_wb_vld", 64'(wb_vld), 64'd0);
      chk("rst_wb_rd", 64'(wb_rd), 64'd0);
      chk("rst_wb_data", wb_data, 64'd0);
      chk("rst_stall", 64'(stall), 64'd0);
      chk("rst_ovf", 64'(ovf), 64'd0);
      rstn = 1'b1;

      // 1: single push, drains next cycle
      wb_rdy = 1'b1;
      push(3, 64'hDEAD_BEEF);
      tick();
      alu_vld = 1'b0;
      chk("t1_wb_vld", 64'(wb_vld), 64'd1);
      chk("t1_wb_rd", 64'(wb_rd), 64'd3);
      chk("t1_wb_data", wb_data, 64'hDEAD_BEEF);
      tick();
      chk("t1_empty", 64'(wb_vld), 64'd0);

      // 2: rd=x0 is discarded
      push(0, 64'h55);
      #1 chk("t2_byp_hit", 64'(byp_hit), 64'd0);
      tick();
      alu_vld = 1'b0;
      chk("t2_wb_vld", 64'(wb_vld), 64'd0);
      chk("t2_stall", 64'(stall), 64'd0);

      // 3: fill, overflow, ordered drain
      wb_rdy = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         push(i, 64'h100 + 64'(i));
         tick();
         if (i == 2) chk("t3_stall_c2", 64'(stall), 64'd0);
         if (i == 3) chk("t3_stall_c3", 64'(stall), 64'd1);
      end
      alu_vld = 1'b0;
      chk("t3_ovf", 64'(ovf), 64'd1);
      wb_rdy = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         chk("t3_drain_rd", 64'(wb_rd), 64'(i));
         chk("t3_drain_data", wb_data, 64'h100 + 64'(i));
         tick();
      end
      chk("t3_empty", 64'(wb_vld), 64'd0);
      chk("t3_ovf_sticky", 64'(ovf), 64'd1);
      do_reset();
      chk("t3_ovf_cleared", 64'(ovf), 64'd0);

      // 4: bypass priority
      wb_rdy = 1'b0;
      push(7, 64'h10); tick();
      push(7, 64'h20); tick();
      alu_vld = 1'b0;
      byp_rs  = 5'd7;
      #1;
      chk("t4_hit", 64'(byp_hit), 64'd1);
      chk("t4_youngest", byp_data, 64'h20);
      push(7, 64'h30);
      #1;
      chk("t4_incoming", byp_data, 64'h30);
      byp_rs = 5'd8;
      #1 chk("t4_miss", 64'(byp_hit), 64'd0);
      alu_vld = 1'b0;
      wb_rdy  = 1'b1;
      tick(); tick();
      chk("t4_empty", 64'(wb_vld), 64'd0);

      // 5: full with simultaneous push/pop, pointers wrap three times
      wb_rdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         push(10 + i, 64'h1000 + 64'(10 + i));
         tick();
      end
      wb_rdy = 1'b1;
      for (int k = 0; k < 12; k++) begin
         push(14 + k, 64'h1000 + 64'(14 + k));
         chk("t5_rd", 64'(wb_rd), 64'(10 + k));
         chk("t5_stall", 64'(stall), 64'd1);
         tick();
      end
      alu_vld = 1'b0;
      chk("t5_ovf", 64'(ovf), 64'd0);
      for (int k = 12; k < 16; k++) begin
         chk("t5_tail_rd", 64'(wb_rd), 64'(10 + k));
         chk("t5_tail_data", wb_data, 64'h1000 + 64'(10 + k));
         tick();
      end
      chk("t5_empty", 64'(wb_vld), 64'd0);

      // 6: flush with concurrent push and pop
      wb_rdy = 1'b0;
      push(20, 64'h2020); tick();
      push(21, 64'h2121); tick();
      flush  = 1'b1;
      wb_rdy = 1'b1;
      push(9, 64'h99);
      tick();
      flush   = 1'b0;
      alu_vld = 1'b0;
      byp_rs  = 5'd9;
      #1;
      chk("t6_wb_vld", 64'(wb_vld), 64'd0);
      chk("t6_byp_hit", 64'(byp_hit), 64'd0);
      chk("t6_ovf", 64'(ovf), 64'd0);

      // 6b: asynchronous reset mid-drain
      wb_rdy = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         push(i, 64'h300 + 64'(i));
         tick();
      end
      alu_vld = 1'b0;
      wb_rdy  = 1'b1;
      byp_rs  = 5'd2;
      tick();
      #2 rstn = 1'b0;
      #1;
      chk("t6_ar_wb_vld", 64'(wb_vld), 64'd0);
      chk("t6_ar_wb_rd", 64'(wb_rd), 64'd0);
      chk("t6_ar_wb_data", wb_data, 64'd0);
      chk("t6_ar_stall", 64'(stall), 64'd0);
      chk("t6_ar_byp_hit", 64'(byp_hit), 64'd0);
      chk("t6_ar_byp_data", byp_data, 64'd0);
      chk("t6_ar_ovf", 64'(ovf), 64'd0);
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      tick(); tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
